tuner_phy_ctrl_arb: RTL and testbench

//  Arbitrates tuner-code requests from the search (CH_SEARCH) and lock (CH_LOCK) controllers onto the single tuner DAC.

---
 rtl/tuner_phy_pkg.sv | 47 ++++
 rtl/tuner_phy_rr_arb.sv | 48 ++++
 rtl/tuner_phy_ctrl_arb.sv | 182 ++++++++++++++++++
 tb/tb_tuner_phy_ctrl_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tuner_phy_pkg.sv
// ----------------------------------------------------------------------------
// tuner_phy_pkg
// Shared types for the tuner PHY control path.
//   tuner_phy_ctrl_arb_state_e : transaction FSM state of tuner_phy_ctrl_arb
//   tuner_ctrl_ch_e            : requesting controller (also the req/rsp index)
//   CNT_W                      : width of the settle/timeout counter
//   cnt_sat_inc()              : saturating increment for that counter
//   ch_onehot()                : channel -> per-channel strobe vector
// ----------------------------------------------------------------------------
package tuner_phy_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_CTRL_INIT   = 2'd0,
        ARB_CTRL_TUNE   = 2'd1,
        ARB_CTRL_SYNC   = 2'd2,
        ARB_CTRL_COMMIT = 2'd3
    } tuner_phy_ctrl_arb_state_e;

    typedef enum logic {
        CH_SEARCH = 1'b0,
        CH_LOCK   = 1'b1
    } tuner_ctrl_ch_e;

    // Counter stops at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    function automatic logic [1:0] ch_onehot(input tuner_ctrl_ch_e ch);
        logic [1:0] r;
        if (ch == CH_LOCK) begin
            r = 2'b10;
        end else begin
            r = 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/tuner_phy_rr_arb.sv
// ----------------------------------------------------------------------------
// tuner_phy_rr_arb
// Two-way round-robin grant, purely combinational.
//   req_i        : per-channel request, index = tuner_ctrl_ch_e
//   last_grant_i : channel granted most recently
//   grant_o      : chosen channel (only meaningful with grant_vld_o)
//   grant_vld_o  : at least one channel is requesting
// A lone requester always wins; on contention the channel that did not win
// last time is chosen.
// ----------------------------------------------------------------------------
module tuner_phy_rr_arb
    import tuner_phy_pkg::*;
(
    input  logic [1:0]     req_i,
    input  tuner_ctrl_ch_e last_grant_i,
    output tuner_ctrl_ch_e grant_o,
    output logic           grant_vld_o
);

    // Grant selection from the request vector and round-robin history.
    always_comb begin
        grant_o     = CH_SEARCH;
        grant_vld_o = 1'b0;
        case (req_i)
            2'b01: begin
                grant_o     = CH_SEARCH;
                grant_vld_o = 1'b1;
            end
            2'b10: begin
                grant_o     = CH_LOCK;
                grant_vld_o = 1'b1;
            end
            2'b11: begin
                if (last_grant_i == CH_SEARCH) begin
                    grant_o = CH_LOCK;
                end else begin
                    grant_o = CH_SEARCH;
                end
                grant_vld_o = 1'b1;
            end
            default: begin
                grant_o     = CH_SEARCH;
                grant_vld_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tuner_phy_ctrl_arb.sv
// ----------------------------------------------------------------------------
// tuner_phy_ctrl_arb
// Arbitrates tuner-code requests from the search and lock controllers onto
// the single tuner DAC. One granted request = one transaction:
//   INIT (handshake) -> TUNE (code strobe) -> SYNC (settle, then wait for a
//   fresh power sample or timeout) -> COMMIT (response pulse) -> INIT.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-channel request handshake (ready only in INIT)
//   req_code          : per-channel code, [ch*CODE_W +: CODE_W]
//   rsp_valid         : one-cycle pulse to the owning channel in COMMIT
//   rsp_pwr, rsp_err  : captured sample / timeout flag, held between responses
//   tuner_code(_valid): DAC code (changes only at a handshake) and its strobe
//   pwr_valid, pwr_data: power-detector sample stream
//   arb_state         : current FSM state
//   active_ch         : channel owning the current transaction
// ----------------------------------------------------------------------------
module tuner_phy_ctrl_arb
    import tuner_phy_pkg::*;
#(
    parameter int                CODE_W         = 8,
    parameter int                PWR_W          = 8,
    parameter int                SETTLE_CYCLES  = 4,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [CODE_W-1:0] CODE_RESET     = {CODE_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [2*CODE_W-1:0] req_code,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [PWR_W-1:0]    rsp_pwr,
    output logic                rsp_err,
    output logic [CODE_W-1:0]   tuner_code,
    output logic                tuner_code_valid,
    input  logic                pwr_valid,
    input  logic [PWR_W-1:0]    pwr_data,
    output logic [1:0]          arb_state,
    output logic                active_ch
);

    // Terminal counts; the counter restarts at zero between the settle and
    // wait phases so both windows fit in CNT_W bits independently.
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    tuner_phy_ctrl_arb_state_e state_q, state_d;
    tuner_ctrl_ch_e            active_q, active_d;
    tuner_ctrl_ch_e            last_grant_q, last_grant_d;
    logic [CODE_W-1:0]         code_q, code_d;
    logic                      code_vld_q, code_vld_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      settled_q, settled_d;
    logic [1:0]                rsp_valid_q, rsp_valid_d;
    logic [PWR_W-1:0]          rsp_pwr_q, rsp_pwr_d;
    logic                      rsp_err_q, rsp_err_d;

    tuner_ctrl_ch_e            grant_s;
    logic                      grant_vld_s;
    logic [CODE_W-1:0]         code_sel_s;
    logic [1:0]                req_ready_s;

    tuner_phy_rr_arb u_rr_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .grant_vld_o  (grant_vld_s)
    );

    assign code_sel_s = (grant_s == CH_LOCK) ? req_code[2*CODE_W-1:CODE_W]
                                             : req_code[CODE_W-1:0];

    // Ready is offered only in INIT, and only to the granted (requesting) channel.
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_q == ARB_CTRL_INIT) && grant_vld_s) begin
            req_ready_s = ch_onehot(grant_s);
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Transaction FSM next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        last_grant_d = last_grant_q;
        code_d       = code_q;
        code_vld_d   = 1'b0;
        cnt_d        = cnt_q;
        settled_d    = settled_q;
        rsp_valid_d  = 2'b00;
        rsp_pwr_d    = rsp_pwr_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ARB_CTRL_INIT: begin
                if (grant_vld_s) begin
                    code_d       = code_sel_s;
                    code_vld_d   = 1'b1;
                    active_d     = grant_s;
                    last_grant_d = grant_s;
                    state_d      = ARB_CTRL_TUNE;
                end else begin
                    state_d      = ARB_CTRL_INIT;
                end
            end
            ARB_CTRL_TUNE: begin
                cnt_d     = {CNT_W{1'b0}};
                settled_d = 1'b0;
                state_d   = ARB_CTRL_SYNC;
            end
            ARB_CTRL_SYNC: begin
                if (!settled_q) begin
                    // Settle phase: samples are stale, only count.
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d     = {CNT_W{1'b0}};
                        settled_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_sat_inc(cnt_q);
                    end
                end else if (pwr_valid) begin
                    rsp_pwr_d   = pwr_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = ch_onehot(active_q);
                    state_d     = ARB_CTRL_COMMIT;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    rsp_pwr_d   = {PWR_W{1'b0}};
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = ch_onehot(active_q);
                    state_d     = ARB_CTRL_COMMIT;
                end else begin
                    cnt_d       = cnt_sat_inc(cnt_q);
                end
            end
            ARB_CTRL_COMMIT: begin
                state_d = ARB_CTRL_INIT;
            end
            default: begin
                state_d = ARB_CTRL_INIT;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_CTRL_INIT;
            active_q     <= CH_SEARCH;
            last_grant_q <= CH_LOCK;
            code_q       <= CODE_RESET;
            code_vld_q   <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            settled_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_pwr_q    <= {PWR_W{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            last_grant_q <= last_grant_d;
            code_q       <= code_d;
            code_vld_q   <= code_vld_d;
            cnt_q        <= cnt_d;
            settled_q    <= settled_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_pwr_q    <= rsp_pwr_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready        = req_ready_s;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_pwr          = rsp_pwr_q;
    assign rsp_err          = rsp_err_q;
    assign tuner_code       = code_q;
    assign tuner_code_valid = code_vld_q;
    assign arb_state        = state_q;
    assign active_ch        = active_q;

endmodule

// File: tb/tb_tuner_phy_ctrl_arb.sv
// ----------------------------------------------------------------------------
// tb_tuner_phy_ctrl_arb
// Directed scenarios followed by a random phase, all checked every cycle
// against a transaction-timeline model: a handshake at cycle t0 implies the
// code strobe at t0+1, stale samples up to t0+1+SETTLE, the first later
// sample (or the timeout) decides the response, shown one cycle later.
// ----------------------------------------------------------------------------
module tb_tuner_phy_ctrl_arb;
    import tuner_phy_pkg::*;

    localparam int          S  = 4;
    localparam int          T  = 8;
    localparam logic [7:0]  CR = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_code = 16'h0000;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_pwr;
    logic        rsp_err;
    logic [7:0]  tuner_code;
    logic        tuner_code_valid;
    logic        pwr_valid = 1'b0;
    logic [7:0]  pwr_data = 8'h00;
    logic [1:0]  arb_state;
    logic        active_ch;

    always #5 clk = ~clk;

    tuner_phy_ctrl_arb #(
        .CODE_W(8), .PWR_W(8), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CODE_RESET(CR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_pwr(rsp_pwr), .rsp_err(rsp_err),
        .tuner_code(tuner_code), .tuner_code_valid(tuner_code_valid),
        .pwr_valid(pwr_valid), .pwr_data(pwr_data),
        .arb_state(arb_state), .active_ch(active_ch)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int         cyc = 0;
    bit         m_busy;
    int         m_t0;
    logic       m_ch;
    logic       m_last;
    logic [7:0] m_code;
    logic       m_active;
    bit         m_done;
    int         m_rsp_cyc;
    logic [7:0] m_res_pwr, m_rsp_pwr;
    logic       m_res_err, m_rsp_err;
    bit         hs_now;
    logic       hs_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_t0 = 0; m_ch = 1'b0; m_last = 1'b1; m_code = CR;
        m_active = 1'b0; m_done = 0; m_rsp_cyc = 0;
        m_res_pwr = 8'h00; m_rsp_pwr = 8'h00; m_res_err = 1'b0; m_rsp_err = 1'b0;
        hs_now = 0; hs_ch = 1'b0;
    endtask

    task automatic model_check();
        int         k;
        logic [1:0] e_state, e_ready, e_rspv;
        logic       e_tcv, g;
        e_state = ARB_CTRL_INIT; e_ready = 2'b00; e_rspv = 2'b00; e_tcv = 1'b0; g = 1'b0;
        hs_now = 0;
        if (!m_busy) begin
            if (req_valid != 2'b00) begin
                if (req_valid == 2'b11) g = ~m_last;
                else g = req_valid[1];
                e_ready = g ? 2'b10 : 2'b01;
                hs_now = 1;
            end
        end else begin
            k = cyc - m_t0;
            if (m_done && cyc == m_rsp_cyc) begin
                e_state = ARB_CTRL_COMMIT;
                e_rspv = m_ch ? 2'b10 : 2'b01;
                m_rsp_pwr = m_res_pwr;
                m_rsp_err = m_res_err;
            end else if (k == 1) begin
                e_state = ARB_CTRL_TUNE;
                e_tcv = 1'b1;
            end else begin
                e_state = ARB_CTRL_SYNC;
                if (k >= S + 2 && !m_done) begin
                    if (pwr_valid) begin
                        m_done = 1; m_res_pwr = pwr_data; m_res_err = 1'b0; m_rsp_cyc = cyc + 1;
                    end else if (k == S + 1 + T) begin
                        m_done = 1; m_res_pwr = 8'h00; m_res_err = 1'b1; m_rsp_cyc = cyc + 1;
                    end
                end
            end
        end
        chk("arb_state",  32'(arb_state),        32'(e_state));
        chk("req_ready",  32'(req_ready),        32'(e_ready));
        chk("rsp_valid",  32'(rsp_valid),        32'(e_rspv));
        chk("code_valid", 32'(tuner_code_valid), 32'(e_tcv));
        chk("tuner_code", 32'(tuner_code),       32'(m_code));
        chk("active_ch",  32'(active_ch),        32'(m_active));
        chk("rsp_pwr",    32'(rsp_pwr),          32'(m_rsp_pwr));
        chk("rsp_err",    32'(rsp_err),          32'(m_rsp_err));
        if (hs_now) begin
            m_busy = 1; m_t0 = cyc; m_ch = g; m_last = g; m_active = g; m_done = 0;
            m_code = g ? req_code[15:8] : req_code[7:0];
            hs_ch = g;
        end
        if (e_state == ARB_CTRL_COMMIT) m_busy = 0;
        cyc = cyc + 1;
    endtask

    // One clock: drive inputs just after the edge, check at the falling edge.
    task automatic step(input logic [1:0] v, input logic [7:0] cs, input logic [7:0] cl,
                        input logic pv, input logic [7:0] pd);
        @(posedge clk);
        #1;
        req_valid = v; req_code = {cl, cs}; pwr_valid = pv; pwr_data = pd;
        @(negedge clk);
        model_check();
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset();
        req_valid = 2'b00; pwr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(arb_state),        32'(ARB_CTRL_INIT));
        chk("rst_code",  32'(tuner_code),       32'(CR));
        chk("rst_rspv",  32'(rsp_valid),        32'd0);
        chk("rst_tcv",   32'(tuner_code_valid), 32'd0);
        chk("rst_act",   32'(active_ch),        32'd0);
        chk("rst_pwr",   32'(rsp_pwr),          32'd0);
        chk("rst_err",   32'(rsp_err),          32'd0);
        chk("rst_rdy",   32'(req_ready),        32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit lock_granted;
        model_reset();
        @(negedge clk);
        do_reset();

        // Search-only transaction with a sample stream from cycle 2.
        for (int i = 0; i < 10; i++)
            step((i == 0) ? 2'b01 : 2'b00, 8'h3C, 8'h00, (i >= 2), 8'h55);
        chk("t1_code", 32'(tuner_code), 32'h3C);
        chk("t1_pwr",  32'(rsp_pwr),    32'h55);

        // Both channels continuously: SEARCH, LOCK, SEARCH, LOCK after reset.
        do_reset();
        for (int i = 0; i < 32; i++)
            step(2'b11, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom));

        // Pulses only inside the settle window, then one real sample.
        for (int i = 0; i < 12; i++)
            step((i == 0) ? 2'b10 : 2'b00, 8'h11, 8'hC7,
                 ((i >= 2 && i <= 5) || i == 8), (i == 8) ? 8'h77 : 8'hAA);
        chk("t3_pwr", 32'(rsp_pwr), 32'h77);

        // No sample at all: timeout after T wait cycles.
        for (int i = 0; i < 17; i++)
            step((i == 0) ? 2'b01 : 2'b00, 8'h92, 8'h00, 1'b0, 8'h00);
        chk("t4_err",   32'(rsp_err),   32'd1);
        chk("t4_pwr",   32'(rsp_pwr),   32'd0);
        chk("t4_state", 32'(arb_state), 32'(ARB_CTRL_INIT));

        // Lock request arrives mid-transaction and waits for INIT.
        lock_granted = 0;
        for (int i = 0; i < 18; i++) begin
            step(lock_granted ? 2'b00 : ((i == 0) ? 2'b01 : ((i >= 2) ? 2'b10 : 2'b00)),
                 8'h21, 8'hE4, (i >= 2), 8'($urandom));
            if (hs_now && hs_ch) lock_granted = 1;
        end
        chk("t6_granted", 32'(lock_granted), 32'd1);
        chk("t6_code",    32'(tuner_code),   32'hE4);

        // Reset in the middle of SYNC; afterwards contention goes to SEARCH.
        for (int i = 0; i < 6; i++)
            step((i == 0) ? 2'b10 : 2'b00, 8'h00, 8'h6B, 1'b0, 8'h00);
        do_reset();
        step(2'b11, 8'h44, 8'h88, 1'b0, 8'h00);
        chk("t5_grant", 32'(req_ready), 32'h1);
        for (int i = 0; i < 12; i++)
            step(2'b00, 8'h00, 8'h00, 1'b1, 8'h3E);

        // Random traffic, including dropped requests and timeouts.
        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
